// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the L1 data-cache controller.
//   - FSM state enum for dcache_controller
//   - geometry: TAG_W, IDX_W, LINE_W, WORD_W
//   - SRAM tag word layout {valid, dirty, tag}: VALID_BIT, DIRTY_BIT
package dcache_pkg;

  localparam int unsigned TAG_W      = 23;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned LINE_W     = 256;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned SRAM_TAG_W = TAG_W + 2;

  localparam int unsigned VALID_BIT  = 24;
  localparam int unsigned DIRTY_BIT  = 23;

  typedef enum logic [2:0] {
    StIdle,
    StMiss,
    StWriteback,
    StRefill,
    StRefillOk
  } state_e;

endpackage

// File: rtl/dcache_word_merge.sv
// dcache_word_merge: combinational 32-bit word select / insert on a 256-bit line.
// Ports:
//   line_i  - source line
//   sel_i   - word select (address [4:2])
//   word_i  - word to insert at sel_i
//   word_o  - word of line_i at sel_i
//   line_o  - line_i with word sel_i replaced by word_i
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [2:0]        sel_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] word_o,
  output logic [LINE_W-1:0] line_o
);

  logic [7:0] bit_base;
  assign bit_base = {sel_i, 5'b0};

  always_comb begin
    word_o = line_i[bit_base +: WORD_W];
    line_o = line_i;
    line_o[bit_base +: WORD_W] = word_i;
  end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: initiator side of the L1 data-cache SRAM interface.
// Decodes CPU loads/stores, looks up a 2-way SRAM (16 sets, 256-bit lines), stalls the CPU on
// a miss, writes back a dirty victim, refills the line from memory and merges store data.
// Ports:
//   clk_i, rst_i (async, active-low)
//   cpu_*  - CPU request (addr, store data, MemRead, MemWrite), load data out, stall out
//   mem_*  - line-wide memory port; enable held until the one-cycle mem_ack_i
//   sram_* - tag/data SRAM port; sram_*_i carry hit way on hit, LRU victim on miss
// Optional: define DCACHE_STAT_EN to add stat_hit_o / stat_miss_o saturating counters.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [WORD_W-1:0]     cpu_data_i,
  input  logic                  cpu_MemRead_i,
  input  logic                  cpu_MemWrite_i,
  output logic [WORD_W-1:0]     cpu_data_o,
  output logic                  cpu_stall_o,
  input  logic [LINE_W-1:0]     mem_data_i,
  input  logic                  mem_ack_i,
  output logic [31:0]           mem_addr_o,
  output logic [LINE_W-1:0]     mem_data_o,
  output logic                  mem_enable_o,
  output logic                  mem_write_o,
  output logic [IDX_W-1:0]      sram_addr_o,
  output logic [SRAM_TAG_W-1:0] sram_tag_o,
  output logic [LINE_W-1:0]     sram_data_o,
  output logic                  sram_enable_o,
  output logic                  sram_write_o,
  input  logic [SRAM_TAG_W-1:0] sram_tag_i,
  input  logic [LINE_W-1:0]     sram_data_i,
  input  logic                  sram_hit_i
`ifdef DCACHE_STAT_EN
  ,
  output logic [31:0]           stat_hit_o,
  output logic [31:0]           stat_miss_o
`endif
);

  state_e              state_q, state_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_data_q, mem_data_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_write_q, mem_write_d;

  logic                req;
  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [31:0]         req_line_addr;
  logic [LINE_W-1:0]   base_line;
  logic [LINE_W-1:0]   merged_line;
  logic [WORD_W-1:0]   sel_word;
  logic                sram_write;
  logic                unused_addr;

  assign req           = cpu_MemRead_i | cpu_MemWrite_i;
  assign req_tag       = cpu_addr_i[31:9];
  assign req_idx       = cpu_addr_i[8:5];
  assign req_line_addr = {cpu_addr_i[31:5], 5'b0};
  assign unused_addr   = ^cpu_addr_i[1:0];

  // During the refill ack cycle the line comes from memory; otherwise from the SRAM.
  assign base_line = (state_q == StRefill) ? mem_data_i : sram_data_i;

  dcache_word_merge u_word_merge (
    .line_i (base_line),
    .sel_i  (cpu_addr_i[4:2]),
    .word_i (cpu_data_i),
    .word_o (sel_word),
    .line_o (merged_line)
  );

  assign cpu_data_o   = sel_word;
  assign cpu_stall_o  = req & ~((state_q == StIdle) & sram_hit_i);
  assign sram_addr_o  = req_idx;
  // Reset holds the SRAM write strobe low even though the hit path is combinational.
  assign sram_write_o = sram_write & rst_i;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;

  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    mem_enable_d  = mem_enable_q;
    mem_write_d   = mem_write_q;
    sram_enable_o = 1'b0;
    sram_write    = 1'b0;
    sram_tag_o    = {2'b00, req_tag};
    sram_data_o   = base_line;

    unique case (state_q)
      StIdle: begin
        sram_enable_o = req;
        if (req) begin
          if (sram_hit_i) begin
            if (cpu_MemWrite_i) begin
              sram_write  = 1'b1;
              sram_data_o = merged_line;
              sram_tag_o  = {1'b1, 1'b1, req_tag};
            end
          end else begin
            state_d = StMiss;
          end
        end
      end

      StMiss: begin
        sram_enable_o = req;
        mem_enable_d  = 1'b1;
        if (sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT]) begin
          mem_addr_d  = {sram_tag_i[TAG_W-1:0], req_idx, 5'b0};
          mem_data_d  = sram_data_i;
          mem_write_d = 1'b1;
          state_d     = StWriteback;
        end else begin
          mem_addr_d  = req_line_addr;
          mem_write_d = 1'b0;
          state_d     = StRefill;
        end
      end

      StWriteback: begin
        // Chain straight into the refill read; enable stays high.
        if (mem_ack_i) begin
          mem_addr_d  = req_line_addr;
          mem_write_d = 1'b0;
          state_d     = StRefill;
        end
      end

      StRefill: begin
        if (mem_ack_i) begin
          mem_enable_d  = 1'b0;
          sram_enable_o = 1'b1;
          sram_write    = 1'b1;
          sram_data_o   = cpu_MemWrite_i ? merged_line : base_line;
          sram_tag_o    = {1'b1, cpu_MemWrite_i, req_tag};
          state_d       = StRefillOk;
        end
      end

      StRefillOk: begin
        sram_enable_o = req;
        state_d       = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
    end
  end

`ifdef DCACHE_STAT_EN
  logic [31:0] stat_hit_q, stat_miss_q;
  logic        refilled_q;
  logic        hit_evt, miss_evt;

  // The IDLE cycle right after a refill completes a missed request; it is not a new hit.
  assign hit_evt  = (state_q == StIdle) & req & sram_hit_i & ~refilled_q;
  assign miss_evt = (state_q == StIdle) & req & ~sram_hit_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stat_hit_q  <= '0;
      stat_miss_q <= '0;
      refilled_q  <= 1'b0;
    end else begin
      refilled_q <= (state_q == StRefillOk);
      if (hit_evt && (stat_hit_q != 32'hFFFF_FFFF)) begin
        stat_hit_q <= stat_hit_q + 32'd1;
      end
      if (miss_evt && (stat_miss_q != 32'hFFFF_FFFF)) begin
        stat_miss_q <= stat_miss_q + 32'd1;
      end
    end
  end

  assign stat_hit_o  = stat_hit_q;
  assign stat_miss_o = stat_miss_q;
`endif

endmodule

// File: doc/dcache_controller.md
Name:
dcache_controller
Overview:
Initiator side of the L1 data-cache SRAM interface: decodes CPU load/store requests, drives 2-way SRAM lookups, stalls the CPU on a miss, writes back a dirty victim, refills the line from data memory and merges store data. It sits between the MEM stage and the data memory, with one tag/data SRAM instance behind it. Line = 256 bits, 16 sets; SRAM tag word = {valid, dirty, tag[22:0]}.
Parameters:
TAG_W, 23, address tag bits (address [31:9]); SRAM tag word is TAG_W+2
IDX_W, 4, set index bits (address [8:5]); offset is address [4:0], word select is [4:2]
LINE_W, 256, cache line width in bits; 8 words of 32 bits
Ports:
clk_i  in  1  clock; all state changes on posedge
rst_i  in  1  asynchronous reset, active-low
cpu_addr_i  in  32  byte address of the CPU request
cpu_data_i  in  32  store data
cpu_MemRead_i  in  1  load request
cpu_MemWrite_i  in  1  store request (wins if both high)
cpu_data_o  out  32  load data; valid when request high and cpu_stall_o low
cpu_stall_o  out  1  combinational; high while a request is not yet serviced
mem_data_i  in  256  refill line from memory
mem_ack_i  in  1  one-cycle pulse completing the current memory transaction
mem_addr_o  out  32  line-aligned memory address ([4:0]=0)
mem_data_o  out  256  victim line for write-back
mem_enable_o  out  1  memory request; held until mem_ack_i
mem_write_o  out  1  1 = write-back, 0 = refill read
sram_addr_o  out  4  set index to SRAM
sram_tag_o  out  25  {valid, dirty, tag} to SRAM
sram_data_o  out  256  line to SRAM
sram_enable_o  out  1  SRAM access strobe
sram_write_o  out  1  SRAM write (update on posedge)
sram_tag_i  in  25  hit-way tag on hit; LRU victim tag on miss
sram_data_i  in  256  hit-way line on hit; LRU victim line on miss
sram_hit_i  in  1  combinational lookup hit
Behaviour:
- Reset (rst_i low, async): state IDLE; mem_enable_o, mem_write_o, sram_write_o = 0; mem_addr_o, mem_data_o = 0; write-back/refill latches cleared. cpu_stall_o = request (combinational) throughout.
- req = cpu_MemRead_i | cpu_MemWrite_i. sram_enable_o = req in IDLE/MISS/REFILL_OK, 1 in REFILL on ack; sram_addr_o = cpu_addr_i[8:5]; sram_tag_o tag field = cpu_addr_i[31:9].
- cpu_stall_o = req & ~(state==IDLE & sram_hit_i); hit latency 0 cycles.
- IDLE, read hit: cpu_data_o = word [4:2] of sram_data_i, no SRAM write. Write hit: sram_write_o=1, sram_data_o = sram_data_i with selected word replaced by cpu_data_i, sram_tag_o = {1,1,tag}. Miss -> MISS.
- MISS (one cycle): if sram_tag_i valid&dirty: latch victim, mem_addr_o = {sram_tag_i[22:0], index, 5'b0}, mem_data_o = sram_data_i, mem_write_o=1, mem_enable_o=1 -> WRITEBACK; else mem_addr_o = {cpu_addr_i[31:5],5'b0}, mem_write_o=0, mem_enable_o=1 -> REFILL.
- WRITEBACK: hold outputs; on mem_ack_i switch to read of the requested line (enable stays high, no idle cycle) -> REFILL.
- REFILL: hold read; on mem_ack_i: mem_enable_o=0, sram_write_o=1, sram_data_o = mem_data_i (store word merged if write), sram_tag_o = {1, cpu_MemWrite_i, tag} -> REFILL_OK.
- REFILL_OK: re-lookup (must hit) -> IDLE, where the request completes and stall drops.
- mem_ack_i outside WRITEBACK/REFILL ignored. CPU holds request stable while stalled; request dropping mid-miss still completes the memory transaction then returns IDLE.
Optional Feature:
DCACHE_STAT_EN defined: adds outputs stat_hit_o[31:0], stat_miss_o[31:0]; +1 per completed IDLE hit / per MISS entry (refill hits not counted), saturate at 0xFFFF_FFFF, cleared by rst_i.
Undefined: no counters, no extra ports; behaviour otherwise identical.
Decomposition:
Package dcache_pkg: state enum (IDLE, MISS, WRITEBACK, REFILL, REFILL_OK), TAG_W/IDX_W/LINE_W, field offsets (VALID_BIT=24, DIRTY_BIT=23).
One sub-module: dcache_word_merge (combinational 32-bit word select/insert into 256-bit line by offset[4:2]).
Test Plan:
Cold load 0x0000_0124 (index 9), victim invalid -> MISS then read 0x0000_0120; ack after 10 cycles with word1=0xDEADBEEF -> SRAM tag {1,0,0}, stall drops, cpu_data_o=0xDEADBEEF.
Store 0x0000_0124 data 0x12345678 after fill -> no stall, sram_write_o=1, tag dirty=1, only word1 changed.
Load 0x0000_2124 (tag 0x10, index 9), victim dirty tag 0 -> write 0x0000_0120 with victim line, then read 0x0000_2120, stall until REFILL_OK.
rst_i low during WRITEBACK -> mem_enable_o 0 immediately, state IDLE, later stray mem_ack_i ignored.
No request -> cpu_stall_o 0, sram_enable_o 0, no memory traffic; with DCACHE_STAT_EN, scenario 1-3 yield stat_hit_o=1, stat_miss_o=2.
